// File: rtl/mag_window_stats.sv
// mag_window_stats
//   Statistics stage behind the 8-bit vector-magnitude unit. It keeps the last
//   2^LOG2_WIN accepted magnitudes in a circular buffer and reports:
//   - a truncating moving average over that window;
//   - a peak-hold value;
//   - a sticky over-threshold alarm.
//
// Ports
//   clk, rst_n   clock (rising edge) / asynchronous active-low reset
//   ena          global enable, gates sample acceptance
//   clear        synchronous soft clear of all statistics (ignores ena)
//   in_valid     in_data holds a new magnitude this cycle
//   in_data      unsigned magnitude sample
//   threshold    unsigned alarm threshold, sampled on each accept
//   avg_out      floor(window sum / WIN), meaningful when avg_valid
//   avg_valid    window has been filled since reset/clear
//   peak_out     largest accepted sample since reset/clear
//   alarm        sticky: some accepted sample exceeded threshold
//   fill_count   samples currently in the window, saturates at WIN
module mag_window_stats #(
  parameter int DATA_W   = 8,
  parameter int LOG2_WIN = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                clear,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [DATA_W-1:0]   threshold,
  output logic [DATA_W-1:0]   avg_out,
  output logic                avg_valid,
  output logic [DATA_W-1:0]   peak_out,
  output logic                alarm,
  output logic [LOG2_WIN:0]   fill_count
);

  localparam int WIN   = 1 << LOG2_WIN;
  localparam int SUM_W = DATA_W + LOG2_WIN;
  localparam logic [LOG2_WIN:0] WIN_CNT = {1'b1, {LOG2_WIN{1'b0}}};

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

  // Truncating divide of the window sum by WIN.
  function automatic logic [DATA_W-1:0] win_mean(input logic [SUM_W-1:0] s);
    return s[SUM_W-1:LOG2_WIN];
  endfunction

  logic [DATA_W-1:0]   win_mem [WIN];
  logic [LOG2_WIN-1:0] wr_ptr;
  logic [SUM_W-1:0]    sum;
  state_t              state;

  logic                accept;
  logic [DATA_W-1:0]   oldest;
  logic [SUM_W-1:0]    sum_acc;

  state_t              state_n;
  logic [LOG2_WIN-1:0] wr_ptr_n;
  logic [SUM_W-1:0]    sum_n;
  logic [LOG2_WIN:0]   fill_n;
  logic [DATA_W-1:0]   avg_n;
  logic                avg_valid_n;
  logic [DATA_W-1:0]   peak_n;
  logic                alarm_n;

  assign accept = ena & in_valid & ~clear;

  // Stage 0: combinational update. The slot being overwritten is read before
  // the write lands, so once the window is full it is the sample leaving it.
  always_comb begin
    oldest  = (fill_count == WIN_CNT) ? win_mem[wr_ptr] : '0;
    sum_acc = sum + {{LOG2_WIN{1'b0}}, in_data} - {{LOG2_WIN{1'b0}}, oldest};

    state_n     = state;
    wr_ptr_n    = wr_ptr;
    sum_n       = sum;
    fill_n      = fill_count;
    avg_n       = avg_out;
    avg_valid_n = avg_valid;
    peak_n      = peak_out;
    alarm_n     = alarm;

    if (clear) begin
      state_n     = FILL;
      wr_ptr_n    = '0;
      sum_n       = '0;
      fill_n      = '0;
      avg_n       = '0;
      avg_valid_n = 1'b0;
      peak_n      = '0;
      alarm_n     = 1'b0;
    end else if (accept) begin
      wr_ptr_n = wr_ptr + 1'b1;
      sum_n    = sum_acc;
      peak_n   = (in_data > peak_out) ? in_data : peak_out;
      alarm_n  = alarm | (in_data > threshold);
      case (state)
        FILL: begin
          fill_n = fill_count + 1'b1;
          if (fill_n == WIN_CNT) begin
            state_n     = RUN;
            avg_valid_n = 1'b1;
            avg_n       = win_mean(sum_acc);
          end
        end
        RUN: begin
          avg_n = win_mean(sum_acc);
        end
        default: state_n = FILL;
      endcase
    end
  end

  // Stage 1: registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      wr_ptr     <= '0;
      sum        <= '0;
      fill_count <= '0;
      avg_out    <= '0;
      avg_valid  <= 1'b0;
      peak_out   <= '0;
      alarm      <= 1'b0;
    end else begin
      state      <= state_n;
      wr_ptr     <= wr_ptr_n;
      sum        <= sum_n;
      fill_count <= fill_n;
      avg_out    <= avg_n;
      avg_valid  <= avg_valid_n;
      peak_out   <= peak_n;
      alarm      <= alarm_n;
    end
  end

  // Buffer contents are never read until fill_count says they are valid.
  always_ff @(posedge clk) begin
    if (accept) win_mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_mag_window_stats.sv
module tb_mag_window_stats;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena, clear, in_valid;
  logic [7:0] in_data, threshold;
  logic [7:0] avg_out, peak_out;
  logic       avg_valid, alarm;
  logic [3:0] fill_count;

  int total = 0;
  int bad   = 0;

  mag_window_stats #(.DATA_W(8), .LOG2_WIN(3)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .threshold(threshold),
    .avg_out(avg_out), .avg_valid(avg_valid), .peak_out(peak_out),
    .alarm(alarm), .fill_count(fill_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drive inputs, let one rising edge pass, return at the
  // following negedge where outputs are stable.
  task automatic step(input logic e, input logic v, input logic c, input logic [7:0] d);
    ena = e; in_valid = v; clear = c; in_data = d;
    @(negedge clk);
  endtask

  task automatic chk_all(input string tag, input int av, input int avv,
                         input int pk, input int al, input int fc);
    chk({tag, ".avg"},   avg_out,    av);
    chk({tag, ".avgv"},  avg_valid,  avv);
    chk({tag, ".peak"},  peak_out,   pk);
    chk({tag, ".alarm"}, alarm,      al);
    chk({tag, ".fill"},  fill_count, fc);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; clear = 1'b0; in_valid = 1'b0;
    in_data = 8'd0; threshold = 8'd255;
    @(negedge clk);
    @(negedge clk);
    chk_all("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Fill window with 10s; average appears on the 8th accept.
    for (int i = 1; i <= 8; i++) begin
      step(1, 1, 0, 8'd10);
      chk($sformatf("fill%0d.cnt", i), fill_count, i);
      chk($sformatf("fill%0d.avgv", i), avg_valid, (i == 8) ? 1 : 0);
      chk($sformatf("fill%0d.avg", i), avg_out, (i == 8) ? 10 : 0);
    end
    chk("fill.peak", peak_out, 10);

    // Oldest 10 leaves, 90 enters: 160/8 = 20.
    step(1, 1, 0, 8'd90);
    chk_all("run90", 20, 1, 90, 0, 8);

    // Full-scale window: 2040/8 = 255; 255 is not > threshold 255.
    for (int i = 0; i < 8; i++) step(1, 1, 0, 8'd255);
    chk_all("max", 255, 1, 255, 0, 8);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 8'd0);
    chk_all("zero", 0, 1, 255, 0, 8);

    // Strict threshold compare and stickiness.
    threshold = 8'd100;
    step(1, 1, 0, 8'd100);
    chk("thr_eq.alarm", alarm, 0);
    step(1, 1, 0, 8'd101);
    chk("thr_gt.alarm", alarm, 1);
    step(1, 1, 0, 8'd0);
    chk("thr_stk.alarm", alarm, 1);
    chk("thr.avg", avg_out, 25);   // (100+101)/8 = 25

    // Clear drops the concurrent sample.
    step(1, 1, 1, 8'd200);
    chk_all("clear", 0, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      step(1, 1, 0, 8'(i));
      chk($sformatf("refill%0d.avgv", i), avg_valid, (i == 8) ? 1 : 0);
    end
    chk_all("refill", 4, 1, 8, 0, 8);   // 36/8 truncates to 4

    // Disabled: everything holds.
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'd50);
    chk_all("hold", 4, 1, 8, 0, 8);

    // Async reset between edges takes effect without a clock.
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 1, 0, 8'd40);
    chk_all("post_rst1", 0, 0, 40, 0, 1);
    for (int i = 0; i < 7; i++) step(1, 1, 0, 8'd40);
    chk_all("post_rst8", 40, 1, 40, 0, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
